// File: rtl/bus_err_drain.sv
// bus_err_drain: drains error FIFO entries into a valid/ready record stream with a saturating count and coalesced irq
// Define BUS_ERR_DRAIN_TIMESTAMP_EN to stamp each record with a free-running capture timestamp.
module bus_err_drain #(
  parameter int AddrWidth     = 48,
  parameter int MetaDataWidth = 1,
  parameter int ErrBits       = 3,
  parameter int CntWidth      = 16,
  parameter int IrqThreshold  = 4,
  parameter int IrqTimeout    = 1024,
  parameter int TsWidth       = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     drain_en_i,
  input  logic                     err_irq_i,
  input  logic [ErrBits-1:0]       err_code_i,
  input  logic [AddrWidth-1:0]     err_addr_i,
  input  logic [MetaDataWidth-1:0] err_meta_i,
  input  logic                     err_ovf_i,
  output logic                     err_fifo_pop_o,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [ErrBits-1:0]       rec_code_o,
  output logic [AddrWidth-1:0]     rec_addr_o,
  output logic [MetaDataWidth-1:0] rec_meta_o,
  output logic                     rec_ovf_o,
  output logic [TsWidth-1:0]       rec_ts_o,
  output logic [CntWidth-1:0]      err_cnt_o,
  input  logic                     cnt_clr_i,
  output logic                     irq_o,
  input  logic                     irq_ack_i
);
  localparam logic IDLE = 1'b0;
  localparam logic HOLD = 1'b1;
  localparam int TmrWidth = $clog2(IrqTimeout + 1);
  logic state, ovf_seen, cap, hs, irq_set;
  logic [CntWidth-1:0] pend, pend_next;
  logic [TmrWidth-1:0] tmr;
  assign rec_valid_o = state == HOLD;
  assign hs = rec_valid_o & rec_ready_i;
  assign cap = ~rst_i & drain_en_i & err_irq_i & (state == IDLE | hs);
  assign err_fifo_pop_o = cap;
  // An ack coinciding with a delivery restarts coalescing from that one delivery.
  always_comb begin
    pend_next = irq_ack_i ? CntWidth'(hs) : pend + CntWidth'(hs & ~&pend);
    irq_set = pend_next >= CntWidth'(IrqThreshold) | tmr == TmrWidth'(IrqTimeout);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ovf_seen <= 1'b0;
      rec_code_o <= '0;
      rec_addr_o <= '0;
      rec_meta_o <= '0;
      rec_ovf_o <= 1'b0;
      err_cnt_o <= '0;
      pend <= '0;
      tmr <= '0;
      irq_o <= 1'b0;
    end else begin
      state <= cap ? HOLD : hs ? IDLE : state;
      ovf_seen <= ~cap & (ovf_seen | err_ovf_i);
      if (cap) begin
        rec_code_o <= err_code_i;
        rec_addr_o <= err_addr_i;
        rec_meta_o <= err_meta_i;
        rec_ovf_o <= ovf_seen | err_ovf_i;
      end
      err_cnt_o <= cnt_clr_i ? CntWidth'(cap) : err_cnt_o + CntWidth'(cap & ~&err_cnt_o);
      pend <= pend_next;
      tmr <= irq_ack_i ? '0 : tmr + TmrWidth'(pend_next != '0 && tmr != TmrWidth'(IrqTimeout));
      irq_o <= ~irq_ack_i & (irq_o | irq_set);
    end
  end
`ifdef BUS_ERR_DRAIN_TIMESTAMP_EN
  logic [TsWidth-1:0] ts;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts <= '0;
      rec_ts_o <= '0;
    end else begin
      ts <= ts + TsWidth'(1);
      if (cap) rec_ts_o <= ts;
    end
  end
`else
  assign rec_ts_o = '0;
`endif
endmodule

// File: tb/tb_bus_err_drain.sv
// tb_bus_err_drain: randomized and directed stimulus against a queue-based model; monitor scoreboards delivered records
module tb_bus_err_drain;
  localparam int Thr = 4;
  localparam int Tmo = 8;
  localparam int CntMax = 15;
  typedef struct packed {
    logic [2:0]  code;
    logic [47:0] addr;
    logic        meta;
    logic        ovf;
  } rec_t;
  logic clk = 0, rst = 1, drain_en = 0, err_irq = 0, err_ovf = 0, pop;
  logic [2:0] err_code = 0, rec_code;
  logic [47:0] err_addr = 0, rec_addr;
  logic err_meta = 0, rec_meta, rec_ovf, rec_valid, rec_ready = 0;
  logic [31:0] rec_ts;
  logic [3:0] err_cnt;
  logic cnt_clr = 0, irq, irq_ack = 0;
  rec_t fifo_q[$];
  rec_t exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit held = 0, acc = 0, irq_m = 0;
  int cnt_m = 0, pend_m = 0, start_m = -1;

  bus_err_drain #(.CntWidth(4), .IrqThreshold(Thr), .IrqTimeout(Tmo)) dut (
    .clk_i(clk), .rst_i(rst), .drain_en_i(drain_en), .err_irq_i(err_irq),
    .err_code_i(err_code), .err_addr_i(err_addr), .err_meta_i(err_meta), .err_ovf_i(err_ovf),
    .err_fifo_pop_o(pop), .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
    .rec_code_o(rec_code), .rec_addr_o(rec_addr), .rec_meta_o(rec_meta), .rec_ovf_o(rec_ovf),
    .rec_ts_o(rec_ts), .err_cnt_o(err_cnt), .cnt_clr_i(cnt_clr), .irq_o(irq), .irq_ack_i(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] code, input logic [47:0] addr);
    rec_t r;
    r.code = code;
    r.addr = addr;
    r.meta = 1'($urandom);
    r.ovf = 0;
    fifo_q.push_back(r);
  endtask

  task automatic push_rand();
    push(3'($urandom), {16'($urandom), 32'($urandom)});
  endtask

  task automatic drive_head();
    err_irq = fifo_q.size() != 0;
    if (err_irq) {err_code, err_addr, err_meta} = {fifo_q[0].code, fifo_q[0].addr, fifo_q[0].meta};
    else {err_code, err_addr, err_meta} = {3'($urandom), 16'($urandom), 32'($urandom), 1'($urandom)};
  endtask

  // One clock of stimulus; the model predicts pops, counts and the interrupt from the rules directly.
  task automatic cycle(input bit de, input bit rdy, input bit ovf, input bit ack, input bit clr);
    bit pop_m, hs_m;
    rec_t r;
    @(negedge clk);
    rst = 0; drain_en = de; rec_ready = rdy; err_ovf = ovf; irq_ack = ack; cnt_clr = clr;
    drive_head();
    #2;
    hs_m = held && rdy;
    pop_m = de && fifo_q.size() != 0 && (!held || hs_m);
    chk("pop", pop, pop_m);
    chk("err_cnt", err_cnt, cnt_m);
    chk("irq", irq, irq_m);
    acc |= ovf;
    if (pop_m) begin
      r = fifo_q.pop_front();
      r.ovf = acc;
      acc = 0;
      exp_q.push_back(r);
    end
    held = pop_m ? 1 : hs_m ? 0 : held;
    cnt_m = clr ? (pop_m ? 1 : 0) : (pop_m && cnt_m < CntMax) ? cnt_m + 1 : cnt_m;
    if (ack) begin
      irq_m = 0;
      pend_m = hs_m ? 1 : 0;
      start_m = hs_m ? cyc + 1 : -1;
    end else begin
      if (hs_m) begin
        pend_m++;
        if (start_m < 0) start_m = cyc;
      end
      irq_m = irq_m || pend_m >= Thr || (start_m >= 0 && cyc >= start_m + Tmo);
    end
    cyc++;
  endtask

  task automatic do_reset();
    repeat (2) begin
      @(negedge clk);
      rst = 1; drain_en = 1; rec_ready = 1; err_ovf = 1; irq_ack = 0; cnt_clr = 0; err_irq = 1;
      #2;
      chk("pop_in_reset", pop, 0);
      cyc++;
    end
    held = 0; acc = 0; cnt_m = 0; pend_m = 0; start_m = -1; irq_m = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 0; drain_en = 0; rec_ready = 0; err_ovf = 0;
    drive_head();
    #2;
    chk("rst_valid", rec_valid, 0);
    chk("rst_rec", {rec_code, rec_addr, rec_meta, rec_ovf}, 0);
    chk("rst_ts", rec_ts, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_irq", irq, 0);
    chk("rst_pop", pop, 0);
    cyc++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && rec_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rec_unexpected at cycle %0d: got record %0h expected none", cyc, {rec_code, rec_addr});
        end else begin
          chk("rec", 64'({rec_code, rec_addr, rec_meta, rec_ovf}), 64'(exp_q[0]));
`ifndef BUS_ERR_DRAIN_TIMESTAMP_EN
          chk("rec_ts", rec_ts, 0);
`endif
          if (rec_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();
    push(3'd5, 48'h1000);
    repeat (3) cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    repeat (3) push_rand();
    repeat (5) cycle(1, 0, 0, 0, 0);
    repeat (4) cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    repeat (3) push_rand();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (4) cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    repeat (5) push_rand();
    repeat (5) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    repeat (3) push_rand();
    repeat (4) cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    repeat (20) cycle(0, 0, 0, 0, 0);
    push_rand();
    repeat (2) cycle(1, 1, 0, 0, 0);
    repeat (14) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    repeat (20) push_rand();
    repeat (22) cycle(1, 1, 0, 0, 0);
    push_rand();
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 0);
    repeat (2) push_rand();
    repeat (4) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (fifo_q.size() < 6 && $urandom_range(2) == 0) push_rand();
      cycle($urandom_range(9) < 8, $urandom_range(9) < 7, $urandom_range(9) == 0,
            $urandom_range(19) == 0, $urandom_range(29) == 0);
    end
    for (int i = 0; i < 100 && (fifo_q.size() != 0 || held); i++) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    chk("drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
